requant_pack: RTL and testbench

Upstream producer for `special_pu`: consumes a stream of signed accumulator results, requantizes each to int8 with multiply/round/shift/saturate, and packs four bytes per 32-bit word. It writes the matrix into the global buffer (gbuf) in the row-major, block-aligned layout that `special_pu` reads through `im_base_addr`/`im_block_align`. It uses the same config-then-start / end-pulse control style as `special_pu`, so a controller can chain the two blocks.

---
 rtl/rq_pkg.sv | 14 +
 rtl/requant_sat.sv | 85 ++++++++
 rtl/requant_pack.sv | 201 ++++++++++++++++++++
 tb/tb_requant_pack.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rq_pkg.sv
// Shared constants and FSM state encoding for the requantize-and-pack output stage.
package rq_pkg;

    localparam int RQ_ACC_WIDTH = 32;
    localparam int RQ_LANES     = 4;

    typedef logic [1:0] rq_state_t;

    localparam rq_state_t ST_IDLE  = 2'd0;
    localparam rq_state_t ST_RUN   = 2'd1;
    localparam rq_state_t ST_DRAIN = 2'd2;
    localparam rq_state_t ST_END   = 2'd3;

endpackage

// File: rtl/requant_sat.sv
// Two-stage requantizer: registered signed product, then round/shift/saturate to int8.
// A sideband word travels alongside each element with matching latency.
module requant_sat
    import rq_pkg::*;
#(
    parameter int ACC_W = RQ_ACC_WIDTH,
    parameter int SB_W  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [ACC_W-1:0] i_acc,
    input  logic [7:0]       i_mult,
    input  logic [4:0]       i_shift,
    input  logic [SB_W-1:0]  i_sb,
    output logic             o_valid,
    output logic [7:0]       o_byte,
    output logic [SB_W-1:0]  o_sb
);

    localparam int PW = ACC_W + 9;
    localparam logic signed [PW-1:0] ONE     = PW'(1);
    localparam logic signed [PW-1:0] SAT_MAX = PW'(127);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-128);

    function automatic logic [7:0] sat8(input logic signed [PW-1:0] v);
        if (v > SAT_MAX) begin
            sat8 = 8'h7f;
        end else if (v < SAT_MIN) begin
            sat8 = 8'h80;
        end else begin
            sat8 = v[7:0];
        end
    endfunction

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_rnd;
    logic signed [PW-1:0] w_sum;
    logic signed [PW-1:0] w_shr;
    logic signed [PW-1:0] r_prod;
    logic                 r_p_vld;
    logic [SB_W-1:0]      r_p_sb;
    logic                 r_valid;
    logic [7:0]           r_byte;
    logic [SB_W-1:0]      r_sb;

    // The multiplier is zero-extended so it is always treated as non-negative.
    assign w_prod = PW'($signed(i_acc)) * PW'($signed({1'b0, i_mult}));

    // Round half up before the arithmetic shift.
    always_comb begin
        w_rnd = '0;
        if (i_shift != 5'd0) begin
            w_rnd = ONE <<< (i_shift - 5'd1);
        end else begin
            w_rnd = '0;
        end
        w_sum = r_prod + w_rnd;
        w_shr = w_sum >>> i_shift;
    end

    // Product stage followed by saturated-byte stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p_vld <= 1'b0;
            r_prod  <= '0;
            r_p_sb  <= '0;
            r_valid <= 1'b0;
            r_byte  <= 8'h00;
            r_sb    <= '0;
        end else begin
            r_p_vld <= i_valid;
            r_prod  <= w_prod;
            r_p_sb  <= i_sb;
            r_valid <= r_p_vld;
            r_byte  <= sat8(w_shr);
            r_sb    <= r_p_sb;
        end
    end

    assign o_valid = r_valid;
    assign o_byte  = r_byte;
    assign o_sb    = r_sb;

endmodule

// File: rtl/requant_pack.sv
// Requantizes a row-major accumulator stream to int8, packs four lanes per word and
// writes rows into gbuf at base + row*align + word, with config/start/end control.
module requant_pack
    import rq_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = RQ_ACC_WIDTH
) (
    input  logic                  core_clk,
    input  logic                  rst,
    input  logic                  rq_config_en,
    input  logic                  rq_start,
    output logic                  rq_end,
    input  logic [ADDR_WIDTH-1:0] rq_matrix_y_in,
    input  logic [ADDR_WIDTH-1:0] rq_matrix_x_in,
    input  logic [ADDR_WIDTH-1:0] om_base_addr_in,
    input  logic [ADDR_WIDTH-1:0] om_block_align_in,
    input  logic [7:0]            rq_mult_in,
    input  logic [4:0]            rq_shift_in,
    input  logic                  acc_valid,
    output logic                  acc_ready,
    input  logic [ACC_WIDTH-1:0]  acc_data,
    output logic                  gbuf_cen,
    output logic                  gbuf_wen,
    output logic [ADDR_WIDTH-1:0] gbuf_waddr,
    output logic [DATA_WIDTH-1:0] gbuf_din
);

    localparam int AW   = ADDR_WIDTH;
    localparam int WW   = ADDR_WIDTH - 2;
    localparam int CW   = 2 * ADDR_WIDTH;
    localparam int SB_W = 1 + 2 + ADDR_WIDTH;

    rq_state_t       r_state;
    logic [AW-1:0]   r_y;
    logic [AW-1:0]   r_x4;
    logic [AW-1:0]   r_base;
    logic [AW-1:0]   r_align;
    logic [7:0]      r_mult;
    logic [4:0]      r_shift;
    logic [1:0]      r_lane;
    logic [WW-1:0]   r_word;
    logic [AW-1:0]   r_row_base;
    logic [CW-1:0]   r_elem_cnt;
    logic [CW-1:0]   r_total;
    logic            r_ready;
    logic            r_end;
    logic            r_cen;
    logic            r_wen;
    logic [AW-1:0]   r_waddr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [23:0]     r_lane_data;

    logic [WW-1:0]   w_wpr;
    logic            w_accept;
    logic            w_last_elem;
    logic [AW-1:0]   w_addr;
    logic [SB_W-1:0] w_sb;
    logic            w_s_valid;
    logic [7:0]      w_s_byte;
    logic [SB_W-1:0] w_s_sb;
    logic            w_s_last;
    logic [1:0]      w_s_lane;
    logic [AW-1:0]   w_s_addr;

    assign w_wpr       = r_x4[AW-1:2];
    assign w_accept    = acc_valid & r_ready;
    assign w_last_elem = (r_elem_cnt == (r_total - CW'(1)));
    assign w_addr      = r_row_base + {2'b00, r_word};
    assign w_sb        = {w_last_elem, r_lane, w_addr};

    requant_sat #(
        .ACC_W (ACC_WIDTH),
        .SB_W  (SB_W)
    ) u_sat (
        .i_clk   (core_clk),
        .i_rst   (rst),
        .i_valid (w_accept),
        .i_acc   (acc_data),
        .i_mult  (r_mult),
        .i_shift (r_shift),
        .i_sb    (w_sb),
        .o_valid (w_s_valid),
        .o_byte  (w_s_byte),
        .o_sb    (w_s_sb)
    );

    assign w_s_last = w_s_sb[SB_W-1];
    assign w_s_lane = w_s_sb[AW+1:AW];
    assign w_s_addr = w_s_sb[AW-1:0];

    // Control FSM, config latch and element/word/row counters.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_y        <= '0;
            r_x4       <= '0;
            r_base     <= '0;
            r_align    <= '0;
            r_mult     <= 8'h00;
            r_shift    <= 5'd0;
            r_lane     <= 2'd0;
            r_word     <= '0;
            r_row_base <= '0;
            r_elem_cnt <= '0;
            r_total    <= '0;
            r_ready    <= 1'b0;
            r_end      <= 1'b0;
        end else begin
            r_end <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rq_config_en) begin
                        r_y     <= rq_matrix_y_in;
                        r_x4    <= rq_matrix_x_in & {{(AW-2){1'b1}}, 2'b00};
                        r_base  <= om_base_addr_in;
                        r_align <= om_block_align_in;
                        r_mult  <= rq_mult_in;
                        r_shift <= rq_shift_in;
                    end
                    if (rq_start) begin
                        r_lane     <= 2'd0;
                        r_word     <= '0;
                        r_elem_cnt <= '0;
                        r_row_base <= r_base;
                        r_total    <= CW'(r_y) * CW'(r_x4);
                        if ((r_y == '0) || (r_x4 == '0)) begin
                            r_state <= ST_END;
                        end else begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_elem_cnt <= r_elem_cnt + CW'(1);
                        r_lane     <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            if (r_word == (w_wpr - WW'(1))) begin
                                r_word     <= '0;
                                r_row_base <= r_row_base + r_align;
                            end else begin
                                r_word <= r_word + WW'(1);
                            end
                        end
                        if (w_last_elem) begin
                            r_ready <= 1'b0;
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_s_valid && w_s_last) begin
                        r_state <= ST_END;
                    end
                end
                ST_END: begin
                    r_end   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Lane assembly and the registered gbuf write port; the 4th byte completes a word.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            r_cen       <= 1'b1;
            r_wen       <= 1'b1;
            r_waddr     <= '0;
            r_din       <= '0;
            r_lane_data <= 24'h000000;
        end else begin
            r_cen <= 1'b1;
            r_wen <= 1'b1;
            if (w_s_valid) begin
                if (w_s_lane == 2'd3) begin
                    r_cen   <= 1'b0;
                    r_wen   <= 1'b0;
                    r_waddr <= w_s_addr;
                    r_din   <= {w_s_byte, r_lane_data};
                end else begin
                    r_lane_data[{w_s_lane, 3'b000} +: 8] <= w_s_byte;
                end
            end
        end
    end

    assign acc_ready  = r_ready;
    assign rq_end     = r_end;
    assign gbuf_cen   = r_cen;
    assign gbuf_wen   = r_wen;
    assign gbuf_waddr = r_waddr;
    assign gbuf_din   = r_din;

endmodule

// File: tb/tb_requant_pack.sv
// Randomized scoreboard bench for requant_pack against an arithmetic reference model.
module tb_requant_pack;

    logic        core_clk = 1'b0;
    logic        rst = 1'b1;
    logic        rq_config_en = 1'b0;
    logic        rq_start = 1'b0;
    logic        rq_end;
    logic [11:0] rq_matrix_y_in = 12'd0;
    logic [11:0] rq_matrix_x_in = 12'd0;
    logic [11:0] om_base_addr_in = 12'd0;
    logic [11:0] om_block_align_in = 12'd0;
    logic [7:0]  rq_mult_in = 8'd0;
    logic [4:0]  rq_shift_in = 5'd0;
    logic        acc_valid = 1'b0;
    logic        acc_ready;
    logic [31:0] acc_data = 32'd0;
    logic        gbuf_cen;
    logic        gbuf_wen;
    logic [11:0] gbuf_waddr;
    logic [31:0] gbuf_din;

    requant_pack dut (
        .core_clk          (core_clk),
        .rst               (rst),
        .rq_config_en      (rq_config_en),
        .rq_start          (rq_start),
        .rq_end            (rq_end),
        .rq_matrix_y_in    (rq_matrix_y_in),
        .rq_matrix_x_in    (rq_matrix_x_in),
        .om_base_addr_in   (om_base_addr_in),
        .om_block_align_in (om_block_align_in),
        .rq_mult_in        (rq_mult_in),
        .rq_shift_in       (rq_shift_in),
        .acc_valid         (acc_valid),
        .acc_ready         (acc_ready),
        .acc_data          (acc_data),
        .gbuf_cen          (gbuf_cen),
        .gbuf_wen          (gbuf_wen),
        .gbuf_waddr        (gbuf_waddr),
        .gbuf_din          (gbuf_din)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          elems[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          end_cnt = 0;
    int          end_cyc = 0;
    int          last_wr_cyc = 0;
    logic [31:0] last_din = 32'd0;
    logic [11:0] last_waddr = 12'd0;
    bit          ready_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: multiply, round half up, arithmetic shift, clamp to int8.
    function automatic logic [7:0] model_byte(input int a, input int m, input int s);
        longint p;
        p = longint'(a) * longint'(m);
        if (s > 0) p = p + (longint'(1) <<< (s - 1));
        p = p >>> s;
        if (p > 127) return 8'h7f;
        else if (p < -128) return 8'h80;
        else return p[7:0];
    endfunction

    function automatic int rnd_acc();
        case ($urandom_range(0, 2))
            0: return int'($urandom);
            1: return int'($urandom_range(0, 4000)) - 2000;
            default: return int'($urandom_range(0, 300)) - 150;
        endcase
    endfunction

    task automatic fill_random(input int n);
        elems.delete();
        for (int i = 0; i < n; i++) elems.push_back(rnd_acc());
    endtask

    task automatic push_expected(input int idx, input int x4, input int base, input int align,
                                 input int mult, input int shift);
        wr_t e;
        int row;
        int k;
        row = idx / x4;
        k = (idx % x4) / 4;
        e.addr = 12'((base + row * align + k) & 32'h0000_0fff);
        e.data = {model_byte(elems[idx], mult, shift), model_byte(elems[idx - 1], mult, shift),
                  model_byte(elems[idx - 2], mult, shift), model_byte(elems[idx - 3], mult, shift)};
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge core_clk);
            cyc++;
            if (acc_ready) ready_seen = 1'b1;
            if (rq_end) begin
                end_cnt++;
                end_cyc = cyc;
            end
            if (!gbuf_cen || !gbuf_wen) begin
                chk("wen_matches_cen", 64'(gbuf_wen), 64'(gbuf_cen));
                chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("gbuf_waddr", 64'(gbuf_waddr), 64'(e.addr));
                    chk("gbuf_din", 64'(gbuf_din), 64'(e.data));
                end
                wr_cnt++;
                last_wr_cyc = cyc;
                last_din = gbuf_din;
                last_waddr = gbuf_waddr;
            end
        end
    endtask

    task automatic configure(input int y, input int x, input int base, input int align,
                             input int mult, input int shift);
        @(negedge core_clk);
        rq_matrix_y_in    = 12'(y);
        rq_matrix_x_in    = 12'(x);
        om_base_addr_in   = 12'(base);
        om_block_align_in = 12'(align);
        rq_mult_in        = 8'(mult);
        rq_shift_in       = 5'(shift);
        rq_config_en      = 1'b1;
        @(negedge core_clk);
        rq_config_en = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int y, input int x, input int base,
                            input int align, input int mult, input int shift,
                            input bit bubbles, input bit poke);
        int x4;
        int total;
        int idx;
        int guard;
        int wr0;
        int end0;
        bit acc;
        x4 = x & 32'hffff_fffc;
        total = y * x4;
        configure(y, x, base, align, mult, shift);
        wr0 = wr_cnt;
        end0 = end_cnt;
        ready_seen = 1'b0;
        rq_start = 1'b1;
        @(negedge core_clk);
        rq_start = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < total && guard < 20000) begin
            acc_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            acc_data = elems[idx];
            if (poke && idx == 5 && acc_ready) begin
                rq_start = 1'b1;
                rq_config_en = 1'b1;
                rq_matrix_y_in = 12'd1;
                rq_matrix_x_in = 12'd4;
                om_base_addr_in = 12'h555;
                rq_mult_in = 8'd0;
                rq_shift_in = 5'd31;
            end
            acc = acc_valid && acc_ready;
            @(posedge core_clk);
            if (acc) begin
                if (idx % 4 == 3) push_expected(idx, x4, base, align, mult, shift);
                idx++;
            end
            guard++;
            @(negedge core_clk);
            rq_start = 1'b0;
            rq_config_en = 1'b0;
        end
        acc_valid = 1'b0;
        chk({tag, "_accept_in_budget"}, 64'(idx), 64'(total));
        guard = 0;
        while (end_cnt == end0 && guard < 100) begin
            @(negedge core_clk);
            guard++;
        end
        repeat (3) @(negedge core_clk);
        chk({tag, "_end_pulses"}, 64'(end_cnt - end0), 64'd1);
        chk({tag, "_write_count"}, 64'(wr_cnt - wr0), 64'(total / 4));
        chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        if (total > 0) chk({tag, "_end_after_last_write"}, 64'(end_cyc - last_wr_cyc), 64'd1);
        else chk({tag, "_ready_never_high"}, 64'(ready_seen), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_acc_ready"}, 64'(acc_ready), 64'd0);
        chk({tag, "_rq_end"}, 64'(rq_end), 64'd0);
        chk({tag, "_gbuf_cen"}, 64'(gbuf_cen), 64'd1);
        chk({tag, "_gbuf_wen"}, 64'(gbuf_wen), 64'd1);
        chk({tag, "_gbuf_waddr"}, 64'(gbuf_waddr), 64'd0);
        chk({tag, "_gbuf_din"}, 64'(gbuf_din), 64'd0);
    endtask

    task automatic reset_mid_pass();
        int idx;
        int guard;
        int wr0;
        int end0;
        bit acc;
        fill_random(16);
        configure(1, 16, 32'h20, 4, 2, 1);
        wr0 = wr_cnt;
        end0 = end_cnt;
        rq_start = 1'b1;
        @(negedge core_clk);
        rq_start = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < 6 && guard < 100) begin
            acc_valid = 1'b1;
            acc_data = elems[idx];
            acc = acc_ready;
            @(posedge core_clk);
            if (acc) begin
                if (idx % 4 == 3) push_expected(idx, 16, 32'h20, 4, 2, 1);
                idx++;
            end
            guard++;
            @(negedge core_clk);
        end
        acc_valid = 1'b0;
        rst = 1'b1;
        @(posedge core_clk);
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge core_clk);
        rst = 1'b0;
        repeat (10) @(negedge core_clk);
        chk("midrst_writes", 64'(wr_cnt - wr0), 64'd1);
        chk("midrst_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("midrst_no_end", 64'(end_cnt - end0), 64'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(negedge core_clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge core_clk);

        elems = '{1, -1, 127, -128};
        run_pass("basic", 1, 4, 32'h100, 7, 1, 0, 1'b0, 1'b0);
        chk("basic_din", 64'(last_din), 64'h807fff01);
        chk("basic_addr", 64'(last_waddr), 64'h100);

        elems = '{1, -3, 200, -1000};
        run_pass("round", 1, 4, 32'h3a, 1, 3, 2, 1'b0, 1'b0);
        chk("round_din", 64'(last_din), 64'h807ffe01);

        fill_random(320);
        run_pass("contig", 5, 64, 0, 16, int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 12)), 1'b0, 1'b0);
        chk("contig_last_addr", 64'(last_waddr), 64'd79);

        fill_random(16);
        run_pass("wrap", 2, 8, 32'hff0, 32, 5, 3, 1'b0, 1'b0);
        chk("wrap_last_addr", 64'(last_waddr), 64'h011);

        fill_random(60);
        run_pass("bubble_poke", 3, 22, 32'h7f8, 40, int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 31)), 1'b1, 1'b1);

        run_pass("x3", 2, 3, 32'h10, 4, 1, 0, 1'b0, 1'b0);
        run_pass("y0", 0, 8, 32'h10, 4, 1, 0, 1'b0, 1'b0);

        reset_mid_pass();

        fill_random(32);
        run_pass("after_rst", 2, 16, 32'h40, 8, int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 20)), 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
